// File: rtl/dds_pkg.sv
// Shared definitions for the DDS -> PWM output chain.
package dds_pkg;

  // Default sample width; one PWM period lasts 2**DATA_W clocks.
  localparam int DATA_W_DEF = 8;

  // PWM stage run-state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_counter.sv
// Free-running PWM period counter. It holds while disabled, and it
// flags the last clock of each period.
module pwm_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  // Count up while enabled. The counter wraps naturally at 2**W-1 -> 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  end

  // This is the period boundary. It is only meaningful while the counter advances.
  assign wrap = en && (cnt == '1);

endmodule

// File: rtl/pwm_dac_stage.sv
// PWM DAC stage. It turns DDS samples into a single-bit PWM stream.
// A sample is accepted into a holding register, then promoted to the
// active duty register only at a period boundary (or when starting from idle).
module pwm_dac_stage
  import dds_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit SIGNED_IN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              pwm_out,
  output logic              period_done,
  output logic              underrun,
  output logic              busy
);

  localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

  pwm_state_e        state;
  logic [DATA_W-1:0] cnt;
  logic              wrap;
  logic [DATA_W-1:0] hold;
  logic              hold_full;
  logic [DATA_W-1:0] duty;
  logic [DATA_W-1:0] cap_val;
  logic              capture;
  logic              start;
  logic              load;

  // The counter runs in RUN and STOP. It sits at 0 in IDLE.
  pwm_counter #(.W(DATA_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (state != ST_IDLE),
    .cnt  (cnt),
    .wrap (wrap)
  );

  // Two's complement input becomes offset binary by flipping the MSB.
  assign cap_val      = SIGNED_IN ? (sample_in ^ MSB_MASK) : sample_in;
  assign sample_ready = ~hold_full;
  assign capture      = sample_valid && ~hold_full;
  assign start        = (state == ST_IDLE) && en;
  // A full hold is promoted at every boundary, and on leaving idle.
  // A sample arriving on the same edge only becomes visible next boundary.
  assign load         = (wrap || start) && hold_full;

  assign period_done  = wrap;
  assign underrun     = wrap && ~hold_full;

  // Holding register. A capture always wins and keeps it full.
  // Otherwise promotion empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (capture) begin
      hold      <= cap_val;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Active duty changes only at a promotion, so there is never a mid-period change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      duty <= '0;
    else if (load) duty <= hold;
  end

  // Run-state FSM. busy is registered alongside the state it reflects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (en) begin
          state <= ST_RUN;
          busy  <= 1'b1;
        end
        ST_RUN: if (!en) begin
          // Dropping en on the very last clock needs no drain period.
          if (wrap) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (en) begin
            state <= ST_RUN;
          end else if (wrap) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Registered compare. The output lags cnt by one clock and is forced low in idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pwm_out <= 1'b0;
    else      pwm_out <= (state != ST_IDLE) && (cnt < duty);
  end

endmodule

// File: tb/tb_pwm_dac_stage.sv
// Directed bench for pwm_dac_stage with hand-computed expectations.
module tb_pwm_dac_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] sample_in = 8'd0;
  logic       sample_valid = 1'b0;
  logic       sample_ready, pwm_out, period_done, underrun, busy;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] src_q[$];

  always #5 clk = ~clk;

  pwm_dac_stage #(.DATA_W(8), .SIGNED_IN(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_out      (pwm_out),
    .period_done  (period_done),
    .underrun     (underrun),
    .busy         (busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Present the head of the source queue; it stays valid until accepted.
  task automatic start_src();
    if (src_q.size() > 0) begin
      sample_in    = src_q[0];
      sample_valid = 1'b1;
    end
  endtask

  // One clock. Advance the source if the handshake completed on this edge.
  task automatic tick();
    logic acc;
    acc = sample_valid && sample_ready;
    @(posedge clk); #1;
    if (acc && src_q.size() > 0) begin
      void'(src_q.pop_front());
      if (src_q.size() > 0) sample_in = src_q[0];
      else                  sample_valid = 1'b0;
    end
  endtask

  task automatic run(input int n, output int highs, output int dones);
    highs = 0; dones = 0;
    repeat (n) begin
      tick();
      highs += int'(pwm_out);
      dones += int'(period_done);
    end
  endtask

  // Starting from a period_done observation, one full period of samples.
  task automatic period(output int highs, output int dones, output int unders, output int readys);
    highs = 0; dones = 0; unders = 0; readys = 0;
    repeat (256) begin
      tick();
      highs  += int'(pwm_out);
      dones  += int'(period_done);
      unders += int'(underrun);
      readys += int'(sample_ready);
    end
  endtask

  // Clocks until period_done shows, bounded; n reports the clock count.
  task automatic wait_done(output int n, output int highs);
    n = 0; highs = 0;
    while (n < 300) begin
      tick();
      n++;
      highs += int'(pwm_out);
      if (period_done) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, h, d, u, r;

    // Reset state
    #1;
    chk("rst_pwm", pwm_out, 0);
    chk("rst_ready", sample_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", period_done, 0);
    chk("rst_underrun", underrun, 0);
    tick(); tick();
    rst = 1'b1;

    // T2: duty 64
    src_q = {8'd64}; start_src();
    tick();
    chk("t2_ready_full", sample_ready, 0);
    en = 1'b1;
    tick();
    chk("t2_busy", busy, 1);
    chk("t2_ready_loaded", sample_ready, 1);
    wait_done(n, h);
    chk("t2_first_len", n, 255);
    chk("t2_first_high", h, 64);
    chk("t2_first_underrun", underrun, 1);
    period(h, d, u, r);
    chk("t2_high", h, 64);
    chk("t2_done", d, 1);

    // T4: no new samples -> underrun each boundary, duty unchanged
    period(h, d, u, r);
    chk("t4_high_a", h, 64);
    chk("t4_under_a", u, 1);
    period(h, d, u, r);
    chk("t4_high_b", h, 64);
    chk("t4_under_b", u, 1);

    // T3: 0 captured on the boundary edge is not used until the next one
    src_q = {8'd0}; start_src();
    period(h, d, u, r);
    chk("t3_late_high", h, 64);
    chk("t3_late_under", u, 0);
    period(h, d, u, r);
    chk("t3_zero_high", h, 0);
    chk("t3_zero_under", u, 1);
    src_q = {8'd255}; start_src();
    period(h, d, u, r);
    chk("t3_zero_high2", h, 0);
    period(h, d, u, r);
    chk("t3_max_high", h, 255);
    chk("t3_max_done", d, 1);

    // T5: back-pressure with samples 1,2,3 held valid continuously
    src_q = {8'd1, 8'd2, 8'd3}; start_src();
    period(h, d, u, r);
    chk("t5_a_high", h, 255);
    chk("t5_a_ready", r, 0);
    chk("t5_a_under", u, 0);
    period(h, d, u, r);
    chk("t5_b_high", h, 1);
    chk("t5_b_ready", r, 1);
    chk("t5_b_under", u, 0);
    period(h, d, u, r);
    chk("t5_c_high", h, 2);
    chk("t5_c_ready", r, 1);
    period(h, d, u, r);
    chk("t5_d_high", h, 3);
    chk("t5_d_ready", r, 256);
    chk("t5_d_under", u, 1);
    period(h, d, u, r);
    chk("t5_e_high", h, 3);

    // T6: en drops at cnt=100, period completes, then idle
    run(101, h, d);
    chk("t6_pre_high", h, 3);
    en = 1'b0;
    tick();
    chk("t6_stop_busy", busy, 1);
    wait_done(n, h);
    chk("t6_drain_len", n, 154);
    chk("t6_drain_busy", busy, 1);
    tick();
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_pwm", pwm_out, 0);
    run(300, h, d);
    chk("t6_idle_high", h, 0);
    chk("t6_idle_done", d, 0);

    // en re-asserted during STOP resumes with no gap
    en = 1'b1;
    tick();
    chk("rs_busy", busy, 1);
    run(50, h, d);
    chk("rs_high", h, 3);
    en = 1'b0;
    run(10, h, d);
    chk("rs_stop_busy", busy, 1);
    en = 1'b1;
    wait_done(n, h);
    chk("rs_len", n, 195);

    // T1: asynchronous reset mid-run with a sample in the hold
    src_q = {8'd77}; start_src();
    tick(); tick();
    chk("t1_pre_pwm", pwm_out, 1);
    chk("t1_pre_ready", sample_ready, 0);
    chk("t1_pre_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("t1_pwm", pwm_out, 0);
    chk("t1_ready", sample_ready, 1);
    chk("t1_busy", busy, 0);
    chk("t1_done", period_done, 0);
    chk("t1_underrun", underrun, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    chk("t1_restart_busy", busy, 1);
    wait_done(n, h);
    chk("t1_restart_len", n, 255);
    chk("t1_lost_sample_high", h, 0);
    chk("t1_restart_under", underrun, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
